// File: rtl/mod_reduce.sv
// Iterative restoring shift-subtract reducer: value_in mod modulus_in, STEPS bits/clk.
// Optional MOD_REDUCE_QUOTIENT_EN adds the quotient_out port.
module mod_reduce #(
    parameter int IN_WIDTH  = 32,
    parameter int MOD_WIDTH = 16,
    parameter int STEPS     = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [IN_WIDTH-1:0]  value_in,
    input  logic [MOD_WIDTH-1:0] modulus_in,
    output logic                 ready_out,
    output logic                 busy_out,
    output logic [MOD_WIDTH-1:0] value_out,
    output logic                 valid_out,
`ifdef MOD_REDUCE_QUOTIENT_EN
    output logic [IN_WIDTH-1:0]  quotient_out,
`endif
    output logic                 error_out
);

    localparam int N  = IN_WIDTH / STEPS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_e;

    state_e               state_q, state_d;
    logic [IN_WIDTH-1:0]  d_q, d_d;
    logic [MOD_WIDTH-1:0] m_q, m_d;
    logic [MOD_WIDTH:0]   r_q, r_d;
    logic [CW-1:0]        c_q, c_d;
    logic [MOD_WIDTH-1:0] val_q, val_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;

    logic [IN_WIDTH-1:0]  d_step;
    logic [MOD_WIDTH:0]   r_step;
    logic                 take;
    logic [IN_WIDTH-1:0]  q_step;

`ifdef MOD_REDUCE_QUOTIENT_EN
    logic [IN_WIDTH-1:0]  q_q, q_d;
    logic [IN_WIDTH-1:0]  quo_q, quo_d;
`else
    logic [IN_WIDTH-1:0]  q_q;
    assign q_q = '0;
`endif

    // R stays below M, so dropping its MSB on the shift loses nothing.
    always_comb begin
        r_step = r_q;
        d_step = d_q;
        q_step = q_q;
        take   = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            r_step = {r_step[MOD_WIDTH-1:0], d_step[IN_WIDTH-1]};
            d_step = d_step << 1;
            take   = (r_step >= {1'b0, m_q});
            if (take) begin
                r_step = r_step - {1'b0, m_q};
            end
            q_step = (q_step << 1) | IN_WIDTH'(take);
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        m_d     = m_q;
        r_d     = r_q;
        c_d     = c_q;
        val_d   = val_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
        q_d     = q_q;
        quo_d   = quo_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (modulus_in == '0) begin
                        val_d = '0;
                        vld_d = 1'b1;
                        err_d = 1'b1;
`ifdef MOD_REDUCE_QUOTIENT_EN
                        quo_d = '1;
`endif
                    end else begin
                        d_d     = value_in;
                        m_d     = modulus_in;
                        r_d     = '0;
                        c_d     = CW'(N);
                        state_d = CALC;
`ifdef MOD_REDUCE_QUOTIENT_EN
                        q_d     = '0;
`endif
                    end
                end
            end
            CALC: begin
                d_d = d_step;
                r_d = r_step;
                c_d = c_q - CW'(1);
`ifdef MOD_REDUCE_QUOTIENT_EN
                q_d = q_step;
`endif
                if (c_q == CW'(1)) begin
                    val_d   = r_step[MOD_WIDTH-1:0];
                    vld_d   = 1'b1;
                    state_d = IDLE;
`ifdef MOD_REDUCE_QUOTIENT_EN
                    quo_d   = q_step;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            d_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            val_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
            q_q     <= '0;
            quo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            m_q     <= m_d;
            r_q     <= r_d;
            c_q     <= c_d;
            val_q   <= val_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
`ifdef MOD_REDUCE_QUOTIENT_EN
            q_q     <= q_d;
            quo_q   <= quo_d;
`endif
        end
    end

    assign ready_out = (state_q == IDLE);
    assign busy_out  = ~ready_out;
    assign value_out = val_q;
    assign valid_out = vld_q;
    assign error_out = err_q;
`ifdef MOD_REDUCE_QUOTIENT_EN
    assign quotient_out = quo_q;
`else
    logic unused_q;
    assign unused_q = ^{q_step, take};
`endif

endmodule

// File: tb/tb_mod_reduce.sv
// Directed + random bench for mod_reduce against plain % and / arithmetic.
// Define MOD_REDUCE_QUOTIENT_EN to also check quotient_out.
module tb_mod_reduce;

    localparam int IW = 32;
    localparam int MW = 16;
    localparam int ST = 1;
    localparam int N  = IW / ST;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          valid_in = 1'b0;
    logic [IW-1:0] value_in = '0;
    logic [MW-1:0] modulus_in = '0;
    logic          ready_out, busy_out, valid_out, error_out;
    logic [MW-1:0] value_out;
`ifdef MOD_REDUCE_QUOTIENT_EN
    logic [IW-1:0] quotient_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mod_reduce #(.IN_WIDTH(IW), .MOD_WIDTH(MW), .STEPS(ST)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .value_in    (value_in),
        .modulus_in  (modulus_in),
        .ready_out   (ready_out),
        .busy_out    (busy_out),
        .value_out   (value_out),
        .valid_out   (valid_out),
`ifdef MOD_REDUCE_QUOTIENT_EN
        .quotient_out(quotient_out),
`endif
        .error_out   (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(input logic [IW-1:0] v, input logic [MW-1:0] m,
                       input string tag);
        int lat;
        logic [IW-1:0] exp_r, exp_q;
        chk({tag, "/ready"}, 64'(ready_out), 64'd1);
        valid_in   = 1'b1;
        value_in   = v;
        modulus_in = m;
        tick;
        valid_in   = 1'b0;
        value_in   = ~v;
        modulus_in = ~m;
        if (m == '0) begin
            chk({tag, "/z_valid"}, 64'(valid_out), 64'd1);
            chk({tag, "/z_error"}, 64'(error_out), 64'd1);
            chk({tag, "/z_value"}, 64'(value_out), 64'd0);
            chk({tag, "/z_ready"}, 64'(ready_out), 64'd1);
            chk({tag, "/z_busy"}, 64'(busy_out), 64'd0);
`ifdef MOD_REDUCE_QUOTIENT_EN
            chk({tag, "/z_quot"}, 64'(quotient_out), 64'({IW{1'b1}}));
`endif
            tick;
            chk({tag, "/z_vclr"}, 64'(valid_out), 64'd0);
            chk({tag, "/z_eclr"}, 64'(error_out), 64'd0);
            return;
        end
        exp_r = v % IW'(m);
        exp_q = v / IW'(m);
        chk({tag, "/busy"}, 64'(busy_out), 64'd1);
        lat = 0;
        while (!valid_out && lat < 2 * N + 4) begin
            tick;
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(N));
        chk({tag, "/value"}, 64'(value_out), 64'(exp_r[MW-1:0]));
        chk({tag, "/error"}, 64'(error_out), 64'd0);
        chk({tag, "/vbusy"}, 64'(busy_out), 64'd0);
`ifdef MOD_REDUCE_QUOTIENT_EN
        chk({tag, "/quot"}, 64'(quotient_out), 64'(exp_q));
`endif
        tick;
        chk({tag, "/pulse"}, 64'(valid_out), 64'd0);
        chk({tag, "/hold"}, 64'(value_out), 64'(exp_r[MW-1:0]));
    endtask

    initial begin
        int gap;
        logic [IW-1:0] rv;
        logic [MW-1:0] rm;

        #3;
        chk("rst/valid", 64'(valid_out), 64'd0);
        chk("rst/error", 64'(error_out), 64'd0);
        chk("rst/busy", 64'(busy_out), 64'd0);
        chk("rst/ready", 64'(ready_out), 64'd1);
        chk("rst/value", 64'(value_out), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        tick;

        run(32'h0001_0000, 16'hFFF1, "d_fff1");
        run(32'd1000000, 16'd997, "d_997");
        run(32'd5, 16'd7, "d_5m7");
        run(32'd5, 16'd1, "d_m1");
        run(32'hFFFF_FFFF, 16'hFFFF, "d_max");
        run(32'h1234_5678, 16'h0000, "d_zero");

        // back-to-back with valid_in held high
        valid_in   = 1'b1;
        value_in   = 32'd100;
        modulus_in = 16'd7;
        tick;
        value_in   = 32'd200;
        modulus_in = 16'd9;
        gap = 0;
        while (!valid_out && gap < 2 * N + 4) begin
            tick;
            gap++;
        end
        chk("b2b/lat1", 64'(gap), 64'(N));
        chk("b2b/val1", 64'(value_out), 64'd2);
        chk("b2b/ready", 64'(ready_out), 64'd1);
        tick;
        valid_in = 1'b0;
        chk("b2b/busy2", 64'(busy_out), 64'd1);
        gap = 0;
        while (!valid_out && gap < 2 * N + 4) begin
            gap++;
            tick;
        end
        chk("b2b/gap", 64'(gap), 64'(N));
        chk("b2b/val2", 64'(value_out), 64'd2);
        tick;

        // asynchronous reset mid-computation
        valid_in   = 1'b1;
        value_in   = 32'hDEAD_BEEF;
        modulus_in = 16'h1234;
        tick;
        valid_in = 1'b0;
        repeat (9) tick;
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst/busy", 64'(busy_out), 64'd0);
        chk("arst/ready", 64'(ready_out), 64'd1);
        chk("arst/value", 64'(value_out), 64'd0);
        chk("arst/valid", 64'(valid_out), 64'd0);
        valid_in   = 1'b1;
        modulus_in = 16'h0000;
        gap = 0;
        repeat (N + 2) begin
            tick;
            if (valid_out || error_out) gap++;
        end
        chk("arst/novalid", 64'(gap), 64'd0);
        valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        tick;
        run(32'hDEAD_BEEF, 16'h1234, "arst/fresh");

        for (int i = 0; i < 20; i++) begin
            rv = $urandom;
            case (i % 5)
                0: rm = MW'($urandom_range(1, 15));
                1: rm = MW'($urandom_range(0, 1));
                default: rm = MW'($urandom_range(1, 65535));
            endcase
            run(rv, rm, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
